// File: rtl/des_key_schedule_ctrl.sv
// DES key-schedule controller: walks the round-key generator over 16 rounds, caches the
// subkeys and replays them in encrypt (0..15) or decrypt (15..0) order over valid/ready.
module des_key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned ROUND_W    = 4,
  parameter int unsigned KEY_W      = 64,
  parameter int unsigned SUBKEY_W   = 48
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_key_valid,
  input  logic [KEY_W-1:0]    i_key,
  output logic                o_key_ready,
  output logic [KEY_W-1:0]    o_gen_key,
  output logic [ROUND_W-1:0]  o_gen_round,
  input  logic [SUBKEY_W-1:0] i_gen_subkey,
  input  logic                i_start,
  input  logic                i_decrypt,
  output logic                o_rk_valid,
  output logic [SUBKEY_W-1:0] o_rk,
  output logic [ROUND_W-1:0]  o_rk_round,
  output logic                o_rk_last,
  input  logic                i_rk_ready,
  output logic                o_keys_loaded,
  output logic                o_busy
);

  localparam logic [ROUND_W-1:0] LastRound = ROUND_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StGen, StReady, StStream} state_e;

  state_e              state_q, state_d;
  logic                key_ready_q, key_ready_d;
  logic                busy_q, busy_d;
  logic [KEY_W-1:0]    gen_key_q, gen_key_d;
  logic [ROUND_W-1:0]  gen_round_q, gen_round_d;
  logic                loaded_q, loaded_d;
  logic                dir_q, dir_d;
  logic                rk_valid_q, rk_valid_d;
  logic [SUBKEY_W-1:0] rk_q, rk_d;
  logic [ROUND_W-1:0]  rk_round_q, rk_round_d;
  logic                rk_last_q, rk_last_d;

  logic [SUBKEY_W-1:0] bank_q [NUM_ROUNDS];
  logic                bank_we;

  logic                key_hs, start_hs, rk_hs;
  logic [ROUND_W-1:0]  next_idx;

  // o_key_ready is a pure state flag, so the key handshake never depends combinationally on
  // i_key_valid; start loses to a simultaneous key load.
  assign key_hs   = key_ready_q & i_key_valid;
  assign start_hs = (state_q == StReady) & i_start & ~key_hs;
  assign rk_hs    = rk_valid_q & i_rk_ready;

  always_comb begin
    state_d     = state_q;
    gen_key_d   = gen_key_q;
    gen_round_d = gen_round_q;
    loaded_d    = loaded_q;
    dir_d       = dir_q;
    rk_valid_d  = rk_valid_q;
    rk_d        = rk_q;
    rk_round_d  = rk_round_q;
    rk_last_d   = rk_last_q;
    bank_we     = 1'b0;
    next_idx    = '0;

    unique case (state_q)
      StIdle, StReady: begin
        if (key_hs) begin
          gen_key_d   = i_key;
          gen_round_d = '0;
          loaded_d    = 1'b0;
          state_d     = StGen;
        end else if (start_hs) begin
          next_idx   = i_decrypt ? LastRound : '0;
          dir_d      = i_decrypt;
          rk_valid_d = 1'b1;
          rk_d       = bank_q[next_idx];
          rk_round_d = next_idx;
          rk_last_d  = 1'b0;
          state_d    = StStream;
        end
      end
      StGen: begin
        bank_we     = 1'b1;
        gen_round_d = gen_round_q + 1'b1;
        if (gen_round_q == LastRound) begin
          loaded_d = 1'b1;
          state_d  = StReady;
        end
      end
      StStream: begin
        if (rk_hs) begin
          if (rk_last_q) begin
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
            state_d    = StReady;
          end else begin
            next_idx   = dir_q ? rk_round_q - 1'b1 : rk_round_q + 1'b1;
            rk_d       = bank_q[next_idx];
            rk_round_d = next_idx;
            rk_last_d  = dir_q ? (next_idx == '0) : (next_idx == LastRound);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    key_ready_d = (state_d == StIdle) || (state_d == StReady);
    busy_d      = (state_d == StGen) || (state_d == StStream);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      gen_key_q   <= '0;
      gen_round_q <= '0;
      loaded_q    <= 1'b0;
      dir_q       <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_q        <= '0;
      rk_round_q  <= '0;
      rk_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      gen_key_q   <= gen_key_d;
      gen_round_q <= gen_round_d;
      loaded_q    <= loaded_d;
      dir_q       <= dir_d;
      rk_valid_q  <= rk_valid_d;
      rk_q        <= rk_d;
      rk_round_q  <= rk_round_d;
      rk_last_q   <= rk_last_d;
    end
  end

  // Bank contents are don't-care until o_keys_loaded, so no reset is needed here.
  always_ff @(posedge i_clk) begin
    if (bank_we) begin
      bank_q[gen_round_q] <= i_gen_subkey;
    end
  end

  assign o_key_ready   = key_ready_q;
  assign o_busy        = busy_q;
  assign o_gen_key     = gen_key_q;
  assign o_gen_round   = gen_round_q;
  assign o_keys_loaded = loaded_q;
  assign o_rk_valid    = rk_valid_q;
  assign o_rk          = rk_q;
  assign o_rk_round    = rk_round_q;
  assign o_rk_last     = rk_last_q;

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// Bench for des_key_schedule_ctrl: a behavioural DES key schedule acts as the generator and
// as the reference feeding a scoreboard of expected subkey beats.
module tb_des_key_schedule_ctrl;

  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] Key0 = 64'h133457799BBCDFF1;
  localparam logic [63:0] Key1 = 64'h0E329232EA6D0D73;
  localparam logic [47:0] Rk1  = 48'h1B02EFFC7072;
  localparam logic [47:0] Rk16 = 48'hCB3D8B0E17F5;

  typedef struct packed {
    logic [47:0] rk;
    logic [3:0]  rnd;
    logic        last;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_key_valid = 1'b0;
  logic [63:0] i_key = '0;
  logic        o_key_ready;
  logic [63:0] o_gen_key;
  logic [3:0]  o_gen_round;
  logic [47:0] i_gen_subkey;
  logic        i_start = 1'b0;
  logic        i_decrypt = 1'b0;
  logic        o_rk_valid;
  logic [47:0] o_rk;
  logic [3:0]  o_rk_round;
  logic        o_rk_last;
  logic        i_rk_ready = 1'b0;
  logic        o_keys_loaded;
  logic        o_busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] cur_key = '0;
  beat_t       sb [$];

  always #5 i_clk = ~i_clk;

  des_key_schedule_ctrl dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_key_valid   (i_key_valid),
    .i_key         (i_key),
    .o_key_ready   (o_key_ready),
    .o_gen_key     (o_gen_key),
    .o_gen_round   (o_gen_round),
    .i_gen_subkey  (i_gen_subkey),
    .i_start       (i_start),
    .i_decrypt     (i_decrypt),
    .o_rk_valid    (o_rk_valid),
    .o_rk          (o_rk),
    .o_rk_round    (o_rk_round),
    .o_rk_last     (o_rk_last),
    .i_rk_ready    (i_rk_ready),
    .o_keys_loaded (o_keys_loaded),
    .o_busy        (o_busy)
  );

  function automatic logic [47:0] des_subkey(input logic [63:0] key, input logic [3:0] rnd);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int j = 0; j <= int'(rnd); j++) begin
      for (int s = 0; s < SHIFTS[j]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
    return k;
  endfunction

  always_comb i_gen_subkey = des_subkey(o_gen_key, o_gen_round);

  task automatic wait_key_ready();
    int cyc = 0;
    while (o_key_ready !== 1'b1 && cyc < 50) begin
      @(negedge i_clk);
      cyc++;
    end
    n_cmp++;
    if (o_key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait_key_ready: o_key_ready=%b required 1 within 50 cycles", o_key_ready);
    end
  endtask

  // Drives a key at a negedge (cycle T) and follows the 16 GEN cycles.
  task automatic load_key(input logic [63:0] k, input bit chk, input int abort_n);
    wait_key_ready();
    i_key_valid = 1'b1;
    i_key       = k;
    cur_key     = k;
    @(negedge i_clk);
    i_key_valid = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (chk) begin
        n_cmp++;
        if (o_gen_round !== 4'(n) || o_busy !== 1'b1 || o_key_ready !== 1'b0 ||
            o_gen_key !== k) begin
          n_err++;
          $display("FAIL gen_cycle%0d: round=%0d busy=%b kready=%b key=%h required %0d/1/0/%h",
                   n, o_gen_round, o_busy, o_key_ready, o_gen_key, n, k);
        end
      end
      if (n == abort_n) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_keys_loaded !== 1'b0 || o_rk_valid !== 1'b0) begin
          n_err++;
          $display("FAIL gen_reset: busy=%b loaded=%b valid=%b required 0/0/0",
                   o_busy, o_keys_loaded, o_rk_valid);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        return;
      end
      i_start = chk && (n == 3);
      @(negedge i_clk);
      i_start = 1'b0;
    end
    n_cmp++;
    if (o_keys_loaded !== 1'b1 || o_key_ready !== 1'b1 || o_busy !== 1'b0 ||
        o_rk_valid !== 1'b0) begin
      n_err++;
      $display("FAIL gen_done: loaded=%b kready=%b busy=%b valid=%b required 1/1/0/0",
               o_keys_loaded, o_key_ready, o_busy, o_rk_valid);
    end
  endtask

  // Starts a stream at the current negedge and drains it through the scoreboard.
  task automatic run_stream(input logic dec, input bit bp, input bit key_poke, input int abort_at,
                            output logic [47:0] first_rk, output logic [47:0] last_rk,
                            output logic last_flag, output int cycles);
    beat_t exp, held;
    bit    stalled = 1'b0;
    bit    ready;
    int    xfers = 0;
    first_rk = '0; last_rk = '0; last_flag = 1'b0; cycles = 0;
    for (int i = 0; i < 16; i++) begin
      exp.rnd  = dec ? 4'(15 - i) : 4'(i);
      exp.rk   = des_subkey(cur_key, exp.rnd);
      exp.last = (i == 15);
      sb.push_back(exp);
    end
    i_start   = 1'b1;
    i_decrypt = dec;
    @(negedge i_clk);
    i_start   = 1'b0;
    i_decrypt = ~dec;
    n_cmp++;
    if (o_rk_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stream_first_valid: o_rk_valid=%b required 1", o_rk_valid);
    end
    while (xfers < 16 && cycles < 200) begin
      if (abort_at != 0 && xfers == abort_at) break;
      if (key_poke) begin
        i_key_valid = 1'b1;
        i_key       = ~cur_key;
        n_cmp++;
        if (o_key_ready !== 1'b0) begin
          n_err++;
          $display("FAIL stream_key_ready: o_key_ready=%b required 0", o_key_ready);
        end
      end
      if (stalled) begin
        n_cmp++;
        if (o_rk_valid !== 1'b1 || o_rk !== held.rk || o_rk_round !== held.rnd ||
            o_rk_last !== held.last) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b rk=%h rnd=%0d last=%b required 1/%h/%0d/%b",
                   o_rk_valid, o_rk, o_rk_round, o_rk_last, held.rk, held.rnd, held.last);
        end
      end
      ready      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_rk_ready = ready;
      if (o_rk_valid === 1'b1) begin
        stalled = !ready;
        held    = '{rk: o_rk, rnd: o_rk_round, last: o_rk_last};
        if (ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL stream_extra: rk=%h rnd=%0d required no beat", o_rk, o_rk_round);
          end else begin
            exp = sb.pop_front();
            if (o_rk !== exp.rk || o_rk_round !== exp.rnd || o_rk_last !== exp.last) begin
              n_err++;
              $display("FAIL stream_beat%0d: rk=%h rnd=%0d last=%b required %h/%0d/%b",
                       xfers, o_rk, o_rk_round, o_rk_last, exp.rk, exp.rnd, exp.last);
            end
          end
          if (xfers == 0) first_rk = o_rk;
          if (xfers == 15) begin
            last_rk   = o_rk;
            last_flag = o_rk_last;
          end
          xfers++;
        end
      end else begin
        stalled = 1'b0;
      end
      @(negedge i_clk);
      cycles++;
    end
    i_key_valid = 1'b0;
    if (abort_at != 0) begin
      i_rst      = 1'b1;
      i_rk_ready = 1'b0;
      @(negedge i_clk);
      n_cmp++;
      if (o_rk_valid !== 1'b0 || o_keys_loaded !== 1'b0 || o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL stream_reset: valid=%b loaded=%b busy=%b required 0/0/0",
                 o_rk_valid, o_keys_loaded, o_busy);
      end
      i_rst = 1'b0;
      sb.delete();
      @(negedge i_clk);
      return;
    end
    i_rk_ready = 1'b0;
    n_cmp++;
    if (xfers != 16 || sb.size() != 0) begin
      n_err++;
      $display("FAIL stream_count: transfers=%0d left=%0d required 16/0", xfers, sb.size());
      sb.delete();
    end
    n_cmp++;
    if (o_rk_valid !== 1'b0 || o_key_ready !== 1'b1 || o_keys_loaded !== 1'b1 ||
        o_busy !== 1'b0 || o_gen_key !== cur_key) begin
      n_err++;
      $display("FAIL stream_end: valid=%b kready=%b loaded=%b busy=%b key=%h required 0/1/1/0/%h",
               o_rk_valid, o_key_ready, o_keys_loaded, o_busy, o_gen_key, cur_key);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (o_key_ready !== 1'b0 || o_rk_valid !== 1'b0 || o_keys_loaded !== 1'b0 ||
        o_busy !== 1'b0 || o_gen_round !== 4'd0 || o_rk_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: kready=%b valid=%b loaded=%b busy=%b round=%0d required 0s",
               o_key_ready, o_rk_valid, o_keys_loaded, o_busy, o_gen_round);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_key_ready: o_key_ready=%b required 1", o_key_ready);
    end
  endtask

  task automatic test_idle_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (o_rk_valid !== 1'b0 || o_busy !== 1'b0 || o_key_ready !== 1'b1) begin
        n_err++;
        $display("FAIL idle_start: valid=%b busy=%b kready=%b required 0/0/1",
                 o_rk_valid, o_busy, o_key_ready);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_encrypt_decrypt();
    logic [47:0] f, l;
    logic        lf;
    int          cyc;
    load_key(Key0, 1'b1, -1);
    run_stream(1'b0, 1'b0, 1'b0, 0, f, l, lf, cyc);
    n_cmp++;
    if (f !== Rk1 || l !== Rk16 || lf !== 1'b1 || cyc != 16) begin
      n_err++;
      $display("FAIL encrypt_ends: first=%h last=%h flag=%b cycles=%0d required %h/%h/1/16",
               f, l, lf, cyc, Rk1, Rk16);
    end
    // Immediate restart in the cycle after the last handshake.
    run_stream(1'b1, 1'b0, 1'b0, 0, f, l, lf, cyc);
    n_cmp++;
    if (f !== Rk16 || l !== Rk1 || lf !== 1'b1 || cyc != 16) begin
      n_err++;
      $display("FAIL decrypt_ends: first=%h last=%h flag=%b cycles=%0d required %h/%h/1/16",
               f, l, lf, cyc, Rk16, Rk1);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] f, l;
    logic        lf;
    int          cyc;
    run_stream(1'b0, 1'b1, 1'b1, 0, f, l, lf, cyc);
    run_stream(1'b1, 1'b1, 1'b0, 0, f, l, lf, cyc);
  endtask

  task automatic test_key_start_collision();
    logic [47:0] f, l;
    logic        lf;
    int          cyc;
    wait_key_ready();
    i_key_valid = 1'b1;
    i_key       = Key1;
    i_start     = 1'b1;
    cur_key     = Key1;
    @(negedge i_clk);
    i_key_valid = 1'b0;
    i_start     = 1'b0;
    for (int n = 0; n < 16; n++) begin
      n_cmp++;
      if (o_rk_valid !== 1'b0 || o_busy !== 1'b1 || o_keys_loaded !== 1'b0) begin
        n_err++;
        $display("FAIL collision_gen%0d: valid=%b busy=%b loaded=%b required 0/1/0",
                 n, o_rk_valid, o_busy, o_keys_loaded);
      end
      @(negedge i_clk);
    end
    n_cmp++;
    if (o_keys_loaded !== 1'b1 || o_gen_key !== Key1 || o_rk_valid !== 1'b0) begin
      n_err++;
      $display("FAIL collision_done: loaded=%b key=%h valid=%b required 1/%h/0",
               o_keys_loaded, o_gen_key, o_rk_valid, Key1);
    end
    run_stream(1'b0, 1'b0, 1'b0, 0, f, l, lf, cyc);
  endtask

  task automatic test_reset_mid();
    logic [47:0] f, l;
    logic        lf;
    int          cyc;
    load_key(Key0, 1'b0, 7);
    load_key(Key1, 1'b0, -1);
    run_stream(1'b1, 1'b0, 1'b0, 5, f, l, lf, cyc);
    load_key(Key0, 1'b1, -1);
    run_stream(1'b0, 1'b1, 1'b0, 0, f, l, lf, cyc);
    n_cmp++;
    if (f !== Rk1 || l !== Rk16 || lf !== 1'b1) begin
      n_err++;
      $display("FAIL reload_ends: first=%h last=%h flag=%b required %h/%h/1", f, l, lf, Rk1, Rk16);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge i_clk);
    test_reset();
    test_idle_start();
    test_encrypt_decrypt();
    test_backpressure();
    test_key_start_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_ctrl.md
Name: des_key_schedule_ctrl

Overview:
Sequences the combinational round-key generator (64-bit key plus 4-bit round index in, 48-bit subkey out) over all 16 rounds, one round per clock. It caches the 16 subkeys in a local bank and then streams them to the DES round datapath over a valid/ready channel. Subkeys stream in ascending order for encryption and descending order for decryption. It sits between the key-load interface and the round datapath and is the only driver of the generator's key and round inputs.

Parameters:
NUM_ROUNDS, 16, number of subkeys generated and cached; fixed for DES
ROUND_W, 4, width of round index; code 0..15 means round 1..16
KEY_W, 64, width of the input key including parity bits
SUBKEY_W, 48, width of each round subkey

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_key_valid  in  1  new 64-bit key offered
i_key  in  64  key value
o_key_ready  out  1  key accepted this cycle when high with i_key_valid
o_gen_key  out  64  registered key driven to generator
o_gen_round  out  4  round index driven to generator
i_gen_subkey  in  48  generator result for (o_gen_key, o_gen_round), same cycle
i_start  in  1  single-cycle request to stream the cached subkeys
i_decrypt  in  1  sampled with i_start: 0 = order 0..15, 1 = order 15..0
o_rk_valid  out  1  subkey output valid
o_rk  out  48  subkey
o_rk_round  out  4  bank index of o_rk
o_rk_last  out  1  high with the 16th subkey of a stream
i_rk_ready  in  1  datapath accepts o_rk
o_keys_loaded  out  1  bank holds a complete, consistent schedule
o_busy  out  1  high in GEN or STREAM

Behaviour:
- FSM states: IDLE, GEN, READY, STREAM. Reset enters IDLE.
- Reset values: all outputs 0, o_keys_loaded=0, bank contents don't-care.
- o_key_ready = 1 in IDLE and READY, 0 otherwise. It is registered from state only; there is no combinational path from i_key_valid.
- Key handshake at cycle T:
  - o_gen_key <= i_key, o_gen_round <= 0, o_keys_loaded <= 0, state <= GEN.
- GEN, cycle T+1+n for n = 0..15:
  - bank[n] <= i_gen_subkey.
  - o_gen_round increments by 1; it wraps to 0 after 15.
  - After capturing n=15, state <= READY and o_keys_loaded <= 1 (visible at T+17).
  - GEN latency is exactly 16 cycles and is never stalled.
- i_start is honoured only in READY and only if no key handshake occurs in the same cycle. Key load has priority; a dropped i_start has no effect. i_start in IDLE, GEN or STREAM is ignored.
- Start accepted at cycle S:
  - Latch the direction from i_decrypt.
  - Load the index: 0 for encrypt, 15 for decrypt.
  - state <= STREAM.
  - o_rk_valid = 1 from S+1, with o_rk = bank[index] registered.
- STREAM handshake (o_rk_valid & i_rk_ready):
  - The index steps +1 (encrypt) or -1 (decrypt) and the next subkey appears the following cycle.
  - Back-to-back transfers sustain 1 subkey/cycle.
  - While o_rk_valid & !i_rk_ready, o_rk, o_rk_round and o_rk_last hold stable.
- o_rk_last = 1 when the transfer count is 15, i.e. at index 15 (encrypt) or index 0 (decrypt).
- After the last handshake: o_rk_valid <= 0 and state <= READY. A new i_start can be accepted in the cycle immediately after the last handshake.
- The bank and o_keys_loaded persist across streams. Repeated starts replay the same schedule with no regeneration.
- i_key_valid during GEN or STREAM is not accepted, and the key must be held by the source. Changing i_decrypt outside the start cycle has no effect.
- i_rst mid-GEN or mid-STREAM:
  - Next cycle is IDLE with o_rk_valid=0 and o_keys_loaded=0.
  - The partial schedule is invalid and must be reloaded.

Test Plan:
- Load i_key=64'h133457799BBCDFF1 at T -> o_gen_round steps 0..15 over T+1..T+16; o_keys_loaded=1 and o_key_ready=1 at T+17; o_busy high T+1..T+16.
- Encrypt stream with i_rk_ready=1 -> 16 consecutive valid beats, first o_rk=48'h1B02EFFC7072 (o_rk_round 0), last o_rk=48'hCB3D8B0E17F5 with o_rk_last=1 (round 15), then o_rk_valid=0.
- Decrypt stream -> first beat 48'hCB3D8B0E17F5 at round 15, last beat 48'h1B02EFFC7072 at round 0 with o_rk_last=1.
- Random i_rk_ready backpressure (≈50%) -> outputs stable while stalled, exactly 16 transfers, order matches scoreboard; i_key_valid during stream -> o_key_ready=0, no reload.
- i_key_valid and i_start in the same READY cycle -> key taken, start dropped, GEN runs, no o_rk_valid; i_start in IDLE -> no effect.
- Assert i_rst at GEN cycle 7 and at STREAM beat 5 -> IDLE next cycle, o_keys_loaded=0, o_rk_valid=0; a subsequent reload and stream produce the correct 16 keys.
